// File: rtl/pulse_sched_pkg.sv
// Shared types and helpers for the pulse scheduler.
package pulse_sched_pkg;

  localparam int DEFAULT_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } sched_state_t;

  function automatic int wrap_inc(input int idx, input int n);
    if (idx + 32'sd1 >= n) begin
      return 32'sd0;
    end else begin
      return idx + 32'sd1;
    end
  endfunction

endpackage

// File: rtl/pulse_scheduler_rr_arbiter.sv
// Combinational requester arbiter: round-robin from ptr_i, or fixed lowest-index
// priority when PULSE_SCHED_FIXED_PRIO_EN is defined (ptr_i then ignored).
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_id_o,
  output logic          any_o
);

  logic found_s;
  int   idx_s;

  // First requester at or after the search origin wins
  always_comb begin
    found_s  = 1'b0;
    gnt_id_o = '0;
    idx_s    = 0;
    for (int k = 0; k < N; k++) begin
`ifdef PULSE_SCHED_FIXED_PRIO_EN
      idx_s = k;
`else
      idx_s = (int'(ptr_i) + k) % N;
`endif
      if (!found_s && req_i[idx_s]) begin
        found_s  = 1'b1;
        gnt_id_o = IW'(idx_s);
      end else begin
        found_s  = found_s;
      end
    end
    if (found_s) begin
      gnt_o = N'(1) << gnt_id_o;
    end else begin
      gnt_o = '0;
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/pulse_scheduler.sv
// Shares one count pulser between NUM_REQ requesters: arbitrate, issue, await ack/ready.
// Define PULSE_SCHED_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module pulse_scheduler
  import pulse_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int CNT_W   = DEFAULT_CNT_W,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*CNT_W-1:0] req_count,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       req_done,
  input  logic                     pulser_ready,
  input  logic                     pulser_ack,
  output logic                     pulser_valid,
  output logic [CNT_W-1:0]         pulser_count,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy
);

  sched_state_t         state_q, state_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]   req_done_q, req_done_d;
  logic                 pulser_valid_q, pulser_valid_d;
  logic [CNT_W-1:0]     pulser_count_q, pulser_count_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic                 busy_q, busy_d;

  logic [NUM_REQ-1:0]   gnt_s;
  logic [ID_W-1:0]      win_id_s;
  logic                 any_s;
  logic [ID_W-1:0]      arb_ptr_s;
  logic                 grant_s;
  logic [CNT_W-1:0]     win_count_s;

  assign grant_s     = (state_q == IDLE) && pulser_ready && any_s;
  assign win_count_s = req_count[int'(win_id_s)*CNT_W +: CNT_W];

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i    (req_valid),
    .ptr_i    (arb_ptr_s),
    .gnt_o    (gnt_s),
    .gnt_id_o (win_id_s),
    .any_o    (any_s)
  );

`ifdef PULSE_SCHED_FIXED_PRIO_EN
  assign arb_ptr_s = '0;
`else
  logic [ID_W-1:0] ptr_q;

  // Pointer moves just past each winner so it re-enters with lowest priority
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (grant_s) begin
      ptr_q <= ID_W'(wrap_inc(int'(win_id_s), NUM_REQ));
    end else begin
      ptr_q <= ptr_q;
    end
  end

  assign arb_ptr_s = ptr_q;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d        = state_q;
    req_ready_d    = '0;
    req_done_d     = '0;
    pulser_valid_d = 1'b0;
    pulser_count_d = pulser_count_q;
    grant_id_d     = grant_id_q;
    case (state_q)
      IDLE: begin
        if (grant_s) begin
          req_ready_d = gnt_s;
          grant_id_d  = win_id_s;
          // A zero count completes on the grant edge without touching the pulser
          if (win_count_s == {CNT_W{1'b0}}) begin
            req_done_d = gnt_s;
          end else begin
            pulser_count_d = win_count_s;
            pulser_valid_d = 1'b1;
            state_d        = ISSUE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (pulser_ack) begin
          state_d = WAIT_DONE;
        end else begin
          state_d = WAIT_ACK;
        end
      end
      WAIT_DONE: begin
        if (pulser_ready) begin
          req_done_d[grant_id_q] = 1'b1;
          state_d                = IDLE;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      req_ready_q    <= '0;
      req_done_q     <= '0;
      pulser_valid_q <= 1'b0;
      pulser_count_q <= '0;
      grant_id_q     <= '0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_ready_q    <= req_ready_d;
      req_done_q     <= req_done_d;
      pulser_valid_q <= pulser_valid_d;
      pulser_count_q <= pulser_count_d;
      grant_id_q     <= grant_id_d;
      busy_q         <= busy_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign req_done     = req_done_q;
  assign pulser_valid = pulser_valid_q;
  assign pulser_count = pulser_count_q;
  assign grant_id     = grant_id_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed bench for pulse_scheduler with a behavioural count pulser.
module tb_pulse_scheduler;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 32;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*CNT_W-1:0] req_count;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       req_done;
  logic                     pulser_ready;
  logic                     pulser_ack;
  logic                     pulser_valid;
  logic [CNT_W-1:0]         pulser_count;
  logic [1:0]               grant_id;
  logic                     busy;

  logic                     model_ready;
  logic                     model_active;
  logic [CNT_W-1:0]         model_rem;
  logic                     hold_ready;

  int n_cmp = 0;
  int n_bad = 0;

  pulse_scheduler #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_count    (req_count),
    .req_ready    (req_ready),
    .req_done     (req_done),
    .pulser_ready (pulser_ready),
    .pulser_ack   (pulser_ack),
    .pulser_valid (pulser_valid),
    .pulser_count (pulser_count),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  assign pulser_ready = model_ready & ~hold_ready;

  // Pulser: ack one cycle after the strobe, one pulse per cycle, then ready again
  always @(posedge clk) begin
    if (rst) begin
      model_ready  <= 1'b1;
      model_active <= 1'b0;
      model_rem    <= '0;
      pulser_ack   <= 1'b0;
    end else begin
      pulser_ack <= 1'b0;
      if (pulser_valid && model_ready) begin
        pulser_ack   <= 1'b1;
        model_ready  <= 1'b0;
        model_active <= 1'b1;
        model_rem    <= pulser_count;
      end else if (model_active && !pulser_ack) begin
        if (model_rem != '0) begin
          model_rem <= model_rem - 32'd1;
        end else begin
          model_active <= 1'b0;
          model_ready  <= 1'b1;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cnt(input int idx, input logic [31:0] val);
    req_count[idx*CNT_W +: CNT_W] = val;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, 64'(req_ready), 64'd0);
    check_eq({tag, "_done"},  64'(req_done), 64'd0);
    check_eq({tag, "_pval"},  64'(pulser_valid), 64'd0);
    check_eq({tag, "_pcnt"},  64'(pulser_count), 64'd0);
    check_eq({tag, "_gid"},   64'(grant_id), 64'd0);
    check_eq({tag, "_busy"},  64'(busy), 64'd0);
  endtask

  // Called right after a grant edge; follows the request through to its done.
  task automatic run_one(input string tag, input int id, input logic [31:0] cnt);
    logic [3:0] oh;
    int         lat;
    logic       clean;
    oh = 4'd1 << id;
    check_eq({tag, "_ready"}, 64'(req_ready), 64'(oh));
    check_eq({tag, "_pval"},  64'(pulser_valid), 64'd1);
    check_eq({tag, "_pcnt"},  64'(pulser_count), 64'(cnt));
    check_eq({tag, "_gid"},   64'(grant_id), 64'(id));
    check_eq({tag, "_busy"},  64'(busy), 64'd1);
    clean = 1'b1;
    lat   = 0;
    while (req_done == '0 && lat < 60) begin
      step();
      lat++;
      if (req_done == '0) begin
        if (!busy || pulser_valid || req_ready != '0) clean = 1'b0;
      end
    end
    check_eq({tag, "_lat"},   64'(lat), 64'(4 + int'(cnt)));
    check_eq({tag, "_done"},  64'(req_done), 64'(oh));
    check_eq({tag, "_idle"},  64'(busy), 64'd0);
    check_eq({tag, "_quiet"}, 64'(clean), 64'd1);
  endtask

  int exp_ids[5];
  int prio_ids[3];

  initial begin
    clk        = 1'b0;
    rst        = 1'b1;
    req_valid  = '0;
    req_count  = '0;
    hold_ready = 1'b0;
    repeat (2) step();
    check_reset_outputs("rst");
    rst = 1'b0;

    // single request, count 3
    set_cnt(1, 32'd3);
    req_valid = 4'b0010;
    step();
    req_valid = 4'b0000;
    run_one("single", 1, 32'd3);

    // contention, counts 1,2,1,2 held throughout
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_cnt(0, 32'd1); set_cnt(1, 32'd2); set_cnt(2, 32'd1); set_cnt(3, 32'd2);
`ifdef PULSE_SCHED_FIXED_PRIO_EN
    exp_ids = '{0, 0, 0, 0, 0};
`else
    exp_ids = '{0, 1, 2, 3, 0};
`endif
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      run_one($sformatf("cont%0d", k), exp_ids[k], (exp_ids[k] % 2 == 1) ? 32'd2 : 32'd1);
    end
    req_valid = 4'b0000;

    // zero count completes on the grant edge
    set_cnt(2, 32'd0);
    req_valid = 4'b0100;
    step();
    req_valid = 4'b0000;
    check_eq("zero_ready", 64'(req_ready), 64'h4);
    check_eq("zero_done",  64'(req_done), 64'h4);
    check_eq("zero_pval",  64'(pulser_valid), 64'd0);
    check_eq("zero_gid",   64'(grant_id), 64'd2);
    check_eq("zero_busy",  64'(busy), 64'd0);
    step();
    check_eq("zero_after_ready", 64'(req_ready), 64'd0);
    check_eq("zero_after_pval",  64'(pulser_valid), 64'd0);
    check_eq("zero_after_busy",  64'(busy), 64'd0);

    // pulser not ready blocks arbitration
    hold_ready = 1'b1;
    set_cnt(0, 32'd2);
    req_valid = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      step();
      check_eq("nrdy_ready", 64'(req_ready), 64'd0);
      check_eq("nrdy_busy",  64'(busy), 64'd0);
    end
    hold_ready = 1'b0;
    step();
    req_valid = 4'b0000;
    run_one("nrdy_go", 0, 32'd2);

    // reset while waiting for the pulser to finish
    set_cnt(1, 32'd5);
    req_valid = 4'b0010;
    step();
    req_valid = 4'b0000;
    check_eq("mid_gid",  64'(grant_id), 64'd1);
    repeat (4) step();
    check_eq("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("mid_rst");
    step();
    check_eq("mid_nodone", 64'(req_done), 64'd0);
    set_cnt(0, 32'd1);
    set_cnt(3, 32'd1);
    req_valid = 4'b1001;
    step();
    req_valid = 4'b0000;
    run_one("post_rst", 0, 32'd1);

    // priority behaviour with reqs 0 and 3 held
    rst = 1'b1;
    step();
    rst = 1'b0;
`ifdef PULSE_SCHED_FIXED_PRIO_EN
    prio_ids = '{0, 0, 3};
`else
    prio_ids = '{0, 3, 3};
`endif
    req_valid = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) req_valid = 4'b1000;
      step();
      run_one($sformatf("prio%0d", k), prio_ids[k], 32'd1);
    end
    req_valid = 4'b0000;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pulse_scheduler.md
Name: pulse_scheduler

Overview:
- Shares one downstream count pulser between NUM_REQ requesters.
- Each requester offers a pulse count with a valid/ready handshake.
- Round-robin arbitration selects one request at a time. The block issues a single-cycle valid/count to the pulser, waits for its ack, then waits for its ready to return.
- On completion the block signals done to the winning requester. The pulser's pulse output goes straight to the system; this block only sequences the pulser.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- CNT_W, 32, width of each count field and of the pulser count port.
- ID_W, $clog2(NUM_REQ), width of the grant index (derived localparam).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request. Held until the matching req_ready.
- req_count  in  NUM_REQ*CNT_W  packed counts. Requester i uses bits [i*CNT_W +: CNT_W]. Held stable while req_valid is high.
- req_ready  out  NUM_REQ  one-cycle, one-hot pulse: request i accepted.
- req_done  out  NUM_REQ  one-cycle, one-hot pulse: pulses for request i finished.
- pulser_ready  in  1  pulser idle and able to accept.
- pulser_ack  in  1  pulser has latched a count (one-cycle pulse).
- pulser_valid  out  1  single-cycle issue strobe to the pulser.
- pulser_count  out  CNT_W  count presented with pulser_valid. Held after issue.
- grant_id  out  ID_W  index of the current/last granted requester.
- busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are registered. Reset values: req_ready=0, req_done=0, pulser_valid=0, pulser_count=0, grant_id=0, busy=0. Round-robin pointer resets to 0 and state to IDLE.
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
- IDLE:
  - Arbitrate only when pulser_ready=1 and |req_valid.
  - Winner = first i with req_valid[i], searching from the pointer upward with wrap.
  - On the grant edge: req_ready[winner]<=1, grant_id<=winner, pointer<=(winner+1) mod NUM_REQ.
- Zero count in IDLE: if the winner's count is 0, req_done[winner]<=1 on the same edge as req_ready. No dispatch; state stays IDLE. The next grant is possible one cycle later.
- Nonzero count in IDLE: pulser_count<=count, pulser_valid<=1, state<=ISSUE.
- ISSUE: pulser_valid<=0, state<=WAIT_ACK. pulser_valid is high for exactly one cycle.
- WAIT_ACK: on pulser_ack=1, state<=WAIT_DONE. pulser_ready is low from the ack cycle onward.
- WAIT_DONE: on pulser_ready=1, req_done[grant_id]<=1 and state<=IDLE.
- Latency:
  - Request visible in cycle T with pulser_ready=1 gives req_ready and pulser_valid in T+1.
  - req_done asserts one cycle after the pulser's ready returns.
- A requester may hold req_valid after req_ready to request again. It re-enters arbitration with lowest priority relative to the rest.
- req_valid deasserting before req_ready is legal; the request is simply not considered.
- pulser_ack seen outside WAIT_ACK is ignored.
- pulser_ready falling while in IDLE blocks arbitration; nothing is lost.
- Reset mid-operation returns everything to its reset values the next cycle. No done is emitted for the aborted request. The system resets the pulser together with this block.
- Only one request is outstanding at any time. busy=1 in ISSUE, WAIT_ACK and WAIT_DONE.

Optional Feature:
- Macro: PULSE_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. The pointer is not implemented; grant_id and all timing are unchanged.
- Undefined: round-robin as described above.

Decomposition:
- Package pulse_sched_pkg holds:
  - the sched_state_t enum (IDLE, ISSUE, WAIT_ACK, WAIT_DONE) as a 2-bit logic type;
  - the default CNT_W constant;
  - a helper function for the wrap-around index increment.
- Sub-module rr_arbiter (parameter N) is natural. It is combinational: req vector plus pointer in, one-hot grant, grant index and any-valid out. The fixed-priority variant is selected inside it by the macro.

Test Plan:
- Single request: req 1 with count=3 and pulser idle -> req_ready[1] and pulser_valid for one cycle with pulser_count=3, then 3 pulses from the pulser. req_done[1] one cycle after pulser_ready returns; busy high throughout.
- Contention: all 4 valid with counts 1,2,1,2 held continuously -> grants in order 0,1,2,3,0. No overlap; each req_done precedes the next req_ready.
- Zero count: req 2 with count=0 -> req_ready[2] and req_done[2] on the same cycle, pulser_valid never asserts, state stays IDLE.
- Pulser not ready: pulser_ready forced 0 with req 0 valid -> no req_ready. Release pulser_ready -> grant the next cycle.
- Reset mid-operation: rst pulsed in WAIT_DONE (count=5) -> next cycle all outputs 0, busy=0, no req_done. A fresh request is granted to index 0 first.
- With PULSE_SCHED_FIXED_PRIO_EN defined: reqs 0 and 3 both held -> req 0 is granted repeatedly and req 3 only after req 0 drops.
